// File: rtl/regfile_access_arbiter_if.sv
// Bundle of requester handshakes, returned read data and register-file
// strobes shared between the arbiter and its surroundings.
interface regfile_access_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  // requester port 0 (core datapath)
  logic                  REQ0;
  logic                  OP0;
  logic [ADDR_WIDTH-1:0] RA1_0;
  logic [ADDR_WIDTH-1:0] RA2_0;
  logic [ADDR_WIDTH-1:0] WA0;
  logic [DATA_WIDTH-1:0] WD0;
  // requester port 1 (debug/loader)
  logic                  REQ1;
  logic                  OP1;
  logic [ADDR_WIDTH-1:0] RA1_1;
  logic [ADDR_WIDTH-1:0] RA2_1;
  logic [ADDR_WIDTH-1:0] WA1;
  logic [DATA_WIDTH-1:0] WD1;
  // handshake and returned data
  logic                  GNT0;
  logic                  GNT1;
  logic                  DONE0;
  logic                  DONE1;
  logic [DATA_WIDTH-1:0] RDATA1;
  logic [DATA_WIDTH-1:0] RDATA2;
  // register file side
  logic [ADDR_WIDTH-1:0] RF_ADDR_R1;
  logic [ADDR_WIDTH-1:0] RF_ADDR_R2;
  logic [ADDR_WIDTH-1:0] RF_ADDR_W;
  logic [DATA_WIDTH-1:0] RF_DATA_W;
  logic                  RF_READ;
  logic                  RF_WRITE;
  logic [DATA_WIDTH-1:0] RF_DATA_R1;
  logic [DATA_WIDTH-1:0] RF_DATA_R2;

  // arbiter view
  modport slave (
    input  REQ0, OP0, RA1_0, RA2_0, WA0, WD0,
    input  REQ1, OP1, RA1_1, RA2_1, WA1, WD1,
    input  RF_DATA_R1, RF_DATA_R2,
    output GNT0, GNT1, DONE0, DONE1, RDATA1, RDATA2,
    output RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, RF_DATA_W, RF_READ, RF_WRITE
  );

  // requesters plus register file view
  modport master (
    output REQ0, OP0, RA1_0, RA2_0, WA0, WD0,
    output REQ1, OP1, RA1_1, RA2_1, WA1, WD1,
    output RF_DATA_R1, RF_DATA_R2,
    input  GNT0, GNT1, DONE0, DONE1, RDATA1, RDATA2,
    input  RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, RF_DATA_W, RF_READ, RF_WRITE
  );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Two-port round-robin arbiter/sequencer for a shared dual-read register
// file. One transaction in flight: grant -> ISSUE (RF strobes) -> RESP (DONE).
module regfile_access_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter bit ZERO_PROTECT = 1'b1
) (
  input logic                     CLK,
  input logic                     RST,
  regfile_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state_reg;
  logic                  last_port_reg;   // port granted most recently
  logic                  owner_reg;       // port owning the transaction in flight
  logic [1:0]            done_reg;
  logic [DATA_WIDTH-1:0] rdata1_reg;
  logic [DATA_WIDTH-1:0] rdata2_reg;
  logic [ADDR_WIDTH-1:0] rf_addr_r1_reg;
  logic [ADDR_WIDTH-1:0] rf_addr_r2_reg;
  logic [ADDR_WIDTH-1:0] rf_addr_w_reg;
  logic [DATA_WIDTH-1:0] rf_data_w_reg;
  logic                  rf_read_reg;
  logic                  rf_write_reg;

  logic [1:0]            req;
  logic [1:0]            win;
  logic [1:0]            gnt;
  logic                  arb_open;

  logic                  sel_op;
  logic [ADDR_WIDTH-1:0] sel_ra1;
  logic [ADDR_WIDTH-1:0] sel_ra2;
  logic [ADDR_WIDTH-1:0] sel_wa;
  logic [DATA_WIDTH-1:0] sel_wd;
  logic                  sel_blocked;

  assign req = {bus.REQ1, bus.REQ0};

  // Arbitration is live in IDLE and RESP only; a reset cycle never grants.
  assign arb_open = !RST && ((state_reg == IDLE) || (state_reg == RESP));

  // A port wins when alone, or on a tie when it was not the last one served.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      localparam int   OTHER   = 1 - gi;
      localparam logic PORT_ID = (gi == 1);
      assign win[gi] = req[gi] && (!req[OTHER] || (last_port_reg != PORT_ID));
      assign gnt[gi] = arb_open && win[gi];
    end
  endgenerate

  // Steer the winning port's command toward the RF output registers.
  always_comb begin
    sel_op  = bus.OP0;
    sel_ra1 = bus.RA1_0;
    sel_ra2 = bus.RA2_0;
    sel_wa  = bus.WA0;
    sel_wd  = bus.WD0;
    if (win[1]) begin
      sel_op  = bus.OP1;
      sel_ra1 = bus.RA1_1;
      sel_ra2 = bus.RA2_1;
      sel_wa  = bus.WA1;
      sel_wd  = bus.WD1;
    end
  end

  // r0 is hard-wired zero when protected: the write completes but never strobes.
  assign sel_blocked = ZERO_PROTECT && (sel_wa == '0);

  // Sequencer FSM; every RF strobe and response output is registered here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      last_port_reg  <= 1'b1;   // port 0 wins the first tie
      owner_reg      <= 1'b0;
      done_reg       <= 2'b00;
      rdata1_reg     <= '0;
      rdata2_reg     <= '0;
      rf_addr_r1_reg <= '0;
      rf_addr_r2_reg <= '0;
      rf_addr_w_reg  <= '0;
      rf_data_w_reg  <= '0;
      rf_read_reg    <= 1'b0;
      rf_write_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, RESP: begin
          done_reg     <= 2'b00;
          rf_read_reg  <= 1'b0;
          rf_write_reg <= 1'b0;
          if (|gnt) begin
            state_reg     <= ISSUE;
            last_port_reg <= gnt[1];
            owner_reg     <= gnt[1];
            if (sel_op) begin
              rf_addr_w_reg <= sel_wa;
              rf_data_w_reg <= sel_wd;
              rf_write_reg  <= !sel_blocked;
            end else begin
              rf_addr_r1_reg <= sel_ra1;
              rf_addr_r2_reg <= sel_ra2;
              rf_read_reg    <= 1'b1;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        ISSUE: begin
          // Only reads refresh RDATA; writes leave the last read data visible.
          if (rf_read_reg) begin
            rdata1_reg <= bus.RF_DATA_R1;
            rdata2_reg <= bus.RF_DATA_R2;
          end
          rf_read_reg  <= 1'b0;
          rf_write_reg <= 1'b0;
          done_reg     <= owner_reg ? 2'b10 : 2'b01;
          state_reg    <= RESP;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.GNT0       = gnt[0];
  assign bus.GNT1       = gnt[1];
  assign bus.DONE0      = done_reg[0];
  assign bus.DONE1      = done_reg[1];
  assign bus.RDATA1     = rdata1_reg;
  assign bus.RDATA2     = rdata2_reg;
  assign bus.RF_ADDR_R1 = rf_addr_r1_reg;
  assign bus.RF_ADDR_R2 = rf_addr_r2_reg;
  assign bus.RF_ADDR_W  = rf_addr_w_reg;
  assign bus.RF_DATA_W  = rf_data_w_reg;
  assign bus.RF_READ    = rf_read_reg;
  assign bus.RF_WRITE   = rf_write_reg;

endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
- Two-requester arbiter and sequencer that shares one 32x32 dual-read register file between port 0 (core datapath) and port 1 (debug/loader).
- Accepts one transaction at a time: either a dual read (two addresses) or a single write.
- Drives the register file's ADDR_R1, ADDR_R2, ADDR_W, DATA_W, READ and WRITE from registered outputs.
- Captures the register file's DATA_R1/DATA_R2 and returns them to the winning requester with a done pulse.

Parameters:
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register address width.
- ZERO_PROTECT, 1, when 1 a write to address 0 is suppressed (WRITE held 0) but still completes with DONE.

Ports:
- CLK  in  1  clock; all state updates on the +ve edge.
- RST  in  1  reset, synchronous and active-high.
- REQ0, REQ1  in  1 each  request; the command is held stable until the matching GNT.
- OP0, OP1  in  1 each  0 = read, 1 = write.
- RA1_0, RA1_1  in  ADDR_WIDTH each  read address 1.
- RA2_0, RA2_1  in  ADDR_WIDTH each  read address 2.
- WA0, WA1  in  ADDR_WIDTH each  write address.
- WD0, WD1  in  DATA_WIDTH each  write data.
- GNT0, GNT1  out  1 each  one-cycle pulse; the command was accepted this cycle.
- DONE0, DONE1  out  1 each  one-cycle pulse; the transaction completed and RDATA is valid.
- RDATA1, RDATA2  out  DATA_WIDTH each  captured read data (shared by both ports, qualified by DONE0/DONE1).
- RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W  out  ADDR_WIDTH  to the register file.
- RF_DATA_W  out  DATA_WIDTH  to the register file.
- RF_READ, RF_WRITE  out  1  to the register file.
- RF_DATA_R1, RF_DATA_R2  in  DATA_WIDTH  from the register file.

Behaviour:
- Reset (RST=1 at a +ve edge):
  - State goes to IDLE; the round-robin pointer is set so port 0 wins the first tie.
  - All outputs go to 0, including RF_READ=RF_WRITE=0 and RDATA1=RDATA2=0.
  - RST has priority over every other event.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - If REQ0 or REQ1 is sampled, the winner's command is latched, GNTx pulses in that same cycle (combinational from REQ in IDLE/RESP), and the state goes to ISSUE.
  - Otherwise the block stays in IDLE.
- Arbitration:
  - Single request: that port wins.
  - Both requesting: the port not granted last wins (round-robin). The pointer updates on each grant.
  - Starvation bound: 1 transaction.
- ISSUE (exactly 1 cycle): the registered RF outputs present the latched command.
  - Read: RF_READ=1, RF_WRITE=0, RF_ADDR_R1/R2 = latched addresses.
  - Write: RF_READ=0, RF_WRITE=1, RF_ADDR_W/RF_DATA_W = latched values.
  - Write to address 0 with ZERO_PROTECT=1: RF_WRITE stays 0.
  - RF_READ and RF_WRITE are never both 1.
  - At the closing edge: RF_DATA_R1/R2 are captured into RDATA1/RDATA2 for reads only (writes leave RDATA unchanged). The state goes to RESP.
- RESP (1 cycle):
  - DONEx pulses for the owner; RF_READ=RF_WRITE=0.
  - Arbitration runs exactly as in IDLE. A pending request is granted this cycle and goes directly to ISSUE, giving 1 transaction per 2 cycles sustained.
- Latency:
  - REQ high at cycle N (IDLE) -> GNT in cycle N -> ISSUE in N+1 -> DONE and RDATA valid in N+2.
  - RDATA holds its value until the next read capture.
- Idle RF outputs: addresses and data retain their last values; READ=WRITE=0.
- Reset mid-transaction:
  - Drops the transaction; no DONE is issued.
  - A write whose ISSUE cycle coincides with the RST edge may land in the register file (RF_WRITE was asserted during that cycle). No guarantee either way.
- A requester deasserting REQ before GNT withdraws the request; the arbiter takes no action.
- Requester rule: the requester must deassert REQ (or present a new command) in the cycle after GNT; otherwise the request is re-arbitrated in RESP.

Test Plan:
- Reset then port 0 read, RA1=3, RA2=7, RF model holding r3=0x11, r7=0x77 -> GNT0 in cycle N, RF_READ=1 in N+1, DONE0 with RDATA1=0x11, RDATA2=0x77 in N+2.
- Port 1 write WA=5, WD=0xDEADBEEF, then port 1 read RA1=5 -> RF_WRITE=1 for exactly one cycle; the read returns RDATA1=0xDEADBEEF; RF_READ and RF_WRITE are never both 1.
- REQ0 and REQ1 held continuously for 6 transactions -> grants 0,1,0,1,0,1; GNT spaced 2 cycles apart; DONE pulses match their owners.
- Port 0 write WA=0, WD=0xFFFF with ZERO_PROTECT=1 -> RF_WRITE stays 0, DONE0 still pulses, a subsequent read of r0 returns 0.
- RST=1 during ISSUE of a port 1 read -> no DONE1; next cycle all outputs are 0; a following simultaneous request grants port 0 first.
- REQ0 raised and dropped in RESP while REQ1 is absent -> GNT0 pulses in the RESP cycle; if REQ0 drops before sampling, the state returns to IDLE with no RF activity.
